// File: rtl/red_stream_accum.sv
// Stream reduction engine: sums each packet of WIDTH-bit words through a single
// 4-bit adder slice, one nibble per cycle, and presents the wrapped packet sum.
module red_stream_accum #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic [CNT_W-1:0] out_count
);

  localparam int NIB   = WIDTH / 4;
  localparam int NIB_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int IDX_W = NIB_W + 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_r,   state_nxt;
  logic [WIDTH-1:0]   acc_r,     acc_nxt;
  logic [WIDTH-1:0]   word_r,    word_nxt;
  logic               last_r,    last_nxt;
  logic [NIB_W-1:0]   nib_r,     nib_nxt;
  logic               carry_r,   carry_nxt;
  logic               sticky_r,  sticky_nxt;
  logic [CNT_W-1:0]   count_r,   count_nxt;
  logic               in_ready_r, in_ready_nxt;
  logic               out_valid_r, out_valid_nxt;

  logic               in_fire_s;
  logic               out_fire_s;
  logic               last_step_s;
  logic [IDX_W-1:0]   idx_s;
  logic [4:0]         step_s;

  assign in_fire_s   = in_valid && in_ready_r;
  assign out_fire_s  = out_valid_r && out_ready;
  assign last_step_s = (nib_r == NIB_W'(NIB - 1));
  assign idx_s       = {nib_r, 2'b00};
  // The one 4-bit adder slice shared by every nibble position.
  assign step_s      = {1'b0, acc_r[idx_s +: 4]} + {1'b0, word_r[idx_s +: 4]} + {4'b0000, carry_r};

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_sum   = acc_r;
  assign out_carry = sticky_r;
  assign out_count = count_r;

  // Next-state, datapath and handshake decode for the reduction FSM.
  always_comb begin
    state_nxt  = state_r;
    acc_nxt    = acc_r;
    word_nxt   = word_r;
    last_nxt   = last_r;
    nib_nxt    = nib_r;
    carry_nxt  = carry_r;
    sticky_nxt = sticky_r;
    count_nxt  = count_r;

    case (state_r)
      S_IDLE, S_WAIT: begin
        if (in_fire_s) begin
          word_nxt  = in_data;
          last_nxt  = in_last;
          carry_nxt = 1'b0;
          nib_nxt   = {NIB_W{1'b0}};
          state_nxt = S_ADD;
        end else begin
          state_nxt = state_r;
        end
      end
      S_ADD: begin
        acc_nxt[idx_s +: 4] = step_s[3:0];
        if (last_step_s) begin
          // Carry out of the top nibble is a word-level wrap: fold into sticky.
          sticky_nxt = sticky_r | step_s[4];
          count_nxt  = (count_r == {CNT_W{1'b1}}) ? count_r : count_r + {{(CNT_W-1){1'b0}}, 1'b1};
          carry_nxt  = 1'b0;
          nib_nxt    = {NIB_W{1'b0}};
          state_nxt  = last_r ? S_DONE : S_WAIT;
        end else begin
          carry_nxt  = step_s[4];
          nib_nxt    = nib_r + {{(NIB_W-1){1'b0}}, 1'b1};
          state_nxt  = S_ADD;
        end
      end
      S_DONE: begin
        if (out_fire_s) begin
          acc_nxt    = {WIDTH{1'b0}};
          sticky_nxt = 1'b0;
          count_nxt  = {CNT_W{1'b0}};
          state_nxt  = S_IDLE;
        end else begin
          state_nxt  = S_DONE;
        end
      end
      default: begin
        state_nxt  = S_IDLE;
        acc_nxt    = {WIDTH{1'b0}};
        nib_nxt    = {NIB_W{1'b0}};
        carry_nxt  = 1'b0;
        sticky_nxt = 1'b0;
        count_nxt  = {CNT_W{1'b0}};
      end
    endcase

    // Handshake flags are registered from the next state so they switch with it.
    if ((state_nxt == S_IDLE) || (state_nxt == S_WAIT)) begin
      in_ready_nxt = 1'b1;
    end else begin
      in_ready_nxt = 1'b0;
    end
    if (state_nxt == S_DONE) begin
      out_valid_nxt = 1'b1;
    end else begin
      out_valid_nxt = 1'b0;
    end
  end

  // State and datapath registers; reset discards any partial packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      acc_r       <= {WIDTH{1'b0}};
      word_r      <= {WIDTH{1'b0}};
      last_r      <= 1'b0;
      nib_r       <= {NIB_W{1'b0}};
      carry_r     <= 1'b0;
      sticky_r    <= 1'b0;
      count_r     <= {CNT_W{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt;
      acc_r       <= acc_nxt;
      word_r      <= word_nxt;
      last_r      <= last_nxt;
      nib_r       <= nib_nxt;
      carry_r     <= carry_nxt;
      sticky_r    <= sticky_nxt;
      count_r     <= count_nxt;
      in_ready_r  <= in_ready_nxt;
      out_valid_r <= out_valid_nxt;
    end
  end

endmodule

// File: tb/tb_red_stream_accum.sv
// Directed and table-driven checks for red_stream_accum, plus a short randomized
// packet run against a behavioural sum model.
module tb_red_stream_accum;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_carry;
  logic [7:0]  out_count;

  int n_checks;
  int n_fail;

  red_stream_accum #(.WIDTH(16), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .out_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int              n;
    logic [3:0][15:0] w;
    logic [15:0]     e_sum;
    logic            e_carry;
    logic [7:0]      e_cnt;
  } vec_t;

  vec_t vecs[10];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_word(input logic [15:0] d, input logic l, input int gap);
    int bound;
    repeat (gap) cyc();
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    bound = 0;
    while (!in_ready && bound < 50) begin
      cyc();
      bound++;
    end
    if (bound >= 50) check("in_ready_timeout", 32'd1, 32'd0);
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic get_result(input string name, input logic [15:0] es, input logic ec,
                            input logic [7:0] en, input int gap);
    int bound;
    bound = 0;
    while (!out_valid && bound < 50) begin
      cyc();
      bound++;
    end
    if (bound >= 50) check({name, "_timeout"}, 32'd1, 32'd0);
    check({name, "_sum"},   {16'h0, out_sum},   {16'h0, es});
    check({name, "_carry"}, {31'h0, out_carry}, {31'h0, ec});
    check({name, "_count"}, {24'h0, out_count}, {24'h0, en});
    repeat (gap) cyc();
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
  endtask

  initial begin
    int          words;
    int unsigned ref_sum;
    logic        ref_carry;
    logic [15:0] d;

    n_checks = 0;
    n_fail   = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    in_last   = 1'b0;
    out_ready = 1'b0;

    vecs[0] = '{1, {16'h0, 16'h0, 16'h0, 16'h1234}, 16'h1234, 1'b0, 8'd1};
    vecs[1] = '{2, {16'h0, 16'h0, 16'h0001, 16'hFFFF}, 16'h0000, 1'b1, 8'd2};
    vecs[2] = '{3, {16'h0, 16'h1000, 16'h00F1, 16'h0F0F}, 16'h2000, 1'b0, 8'd3};
    vecs[3] = '{3, {16'h0, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 16'hFFFD, 1'b1, 8'd3};
    vecs[4] = '{3, {16'h0, 16'h0001, 16'h8000, 16'h8000}, 16'h0001, 1'b1, 8'd3};
    vecs[5] = '{4, {16'h0004, 16'h0003, 16'h0002, 16'h0001}, 16'h000A, 1'b0, 8'd4};
    vecs[6] = '{1, {16'h0, 16'h0, 16'h0, 16'hABCD}, 16'hABCD, 1'b0, 8'd1};
    vecs[7] = '{2, {16'h0, 16'h0, 16'h0000, 16'h0000}, 16'h0000, 1'b0, 8'd2};
    vecs[8] = '{2, {16'h0, 16'h0, 16'h0001, 16'h7FFF}, 16'h8000, 1'b0, 8'd2};
    vecs[9] = '{1, {16'h0, 16'h0, 16'h0, 16'hFFFF}, 16'hFFFF, 1'b0, 8'd1};

    #12;
    check("rst_in_ready",  {31'h0, in_ready},  32'd1);
    check("rst_out_valid", {31'h0, out_valid}, 32'd0);
    check("rst_out_sum",   {16'h0, out_sum},   32'd0);
    check("rst_out_count", {24'h0, out_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // Latency of a single-word packet, then backpressure hold in DONE.
    in_valid = 1'b1; in_data = 16'h1234; in_last = 1'b1;
    cyc();
    in_valid = 1'b1; in_data = 16'hBEEF; in_last = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      check($sformatf("lat_valid_e%0d", k), {31'h0, out_valid}, (k == 4) ? 32'd1 : 32'd0);
      check($sformatf("lat_ready_e%0d", k), {31'h0, in_ready}, 32'd0);
    end
    for (int k = 0; k < 10; k++) begin
      cyc();
      check("bp_sum",   {16'h0, out_sum},   32'h1234);
      check("bp_count", {24'h0, out_count}, 32'd1);
      check("bp_carry", {31'h0, out_carry}, 32'd0);
      check("bp_valid", {31'h0, out_valid}, 32'd1);
      check("bp_ready", {31'h0, in_ready},  32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    check("drain_valid", {31'h0, out_valid}, 32'd0);
    check("drain_ready", {31'h0, in_ready},  32'd1);
    check("drain_sum",   {16'h0, out_sum},   32'd0);
    check("drain_count", {24'h0, out_count}, 32'd0);

    // Table of packets with hand-computed results.
    for (int v = 0; v < 10; v++) begin
      for (int i = 0; i < vecs[v].n; i++) begin
        send_word(vecs[v].w[i], (i == vecs[v].n - 1), 0);
      end
      get_result($sformatf("vec%0d", v), vecs[v].e_sum, vecs[v].e_carry, vecs[v].e_cnt, v % 3);
    end

    // Reset during the second ADD cycle of the second word of a packet.
    send_word(16'h0F00, 1'b0, 0);
    send_word(16'h1111, 1'b0, 0);
    cyc();
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready",  {31'h0, in_ready},  32'd1);
    check("mid_rst_out_valid", {31'h0, out_valid}, 32'd0);
    check("mid_rst_out_sum",   {16'h0, out_sum},   32'd0);
    check("mid_rst_out_carry", {31'h0, out_carry}, 32'd0);
    check("mid_rst_out_count", {24'h0, out_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    send_word(16'h0005, 1'b1, 0);
    get_result("post_rst", 16'h0005, 1'b0, 8'd1, 0);

    // Counter saturation: 300 words of 0x0101 wrap once and saturate the count.
    for (int i = 0; i < 300; i++) begin
      send_word(16'h0101, (i == 299), 0);
    end
    get_result("sat", 16'h2D2C, 1'b1, 8'd255, 0);

    // Randomized packets with valid/ready gaps against a behavioural model.
    for (int p = 0; p < 20; p++) begin
      words     = $urandom_range(1, 12);
      ref_sum   = 0;
      ref_carry = 1'b0;
      for (int i = 0; i < words; i++) begin
        d = 16'($urandom());
        ref_sum = ref_sum + {16'h0, d};
        if (ref_sum > 32'h0000FFFF) begin
          ref_carry = 1'b1;
          ref_sum   = ref_sum & 32'h0000FFFF;
        end
        send_word(d, (i == words - 1), $urandom_range(0, 3));
      end
      get_result($sformatf("rnd%0d", p), ref_sum[15:0], ref_carry, 8'(words), $urandom_range(0, 4));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
